// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered occupancy count, almost-full/empty flags,
// overflow/underflow pulses and a selectable standard or first-word-fall-through read port.
module param_sync_fifo #(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             wfull,
    output logic             rempty,
    output logic             walmost_full,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = 1 << ASIZE;

    if (DSIZE < 1) begin : g_bad_dsize
        $error("param_sync_fifo: DSIZE must be >= 1");
    end
    if (ASIZE < 1) begin : g_bad_asize
        $error("param_sync_fifo: ASIZE must be >= 1");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("param_sync_fifo: AF_THRESH must lie in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("param_sync_fifo: AE_THRESH must lie in 0..DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("param_sync_fifo: FWFT must be 0 or 1");
    end

    localparam logic [ASIZE:0] ONE      = (ASIZE+1)'(1);
    localparam logic [ASIZE:0] FULL_CNT = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AF_CNT   = (ASIZE+1)'(AF_THRESH);
    localparam logic [ASIZE:0] AE_CNT   = (ASIZE+1)'(AE_THRESH);

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [ASIZE:0]   wptr_q, wptr_d;
    logic [ASIZE:0]   rptr_q, rptr_d;
    logic [ASIZE:0]   count_q, count_d;
    logic             overflow_q, underflow_q;
    logic             wr_acc, rd_acc;

    assign wfull         = (count_q == FULL_CNT);
    assign rempty        = (count_q == '0);
    assign walmost_full  = (count_q >= AF_CNT);
    assign ralmost_empty = (count_q <= AE_CNT);
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

    assign wr_acc = winc && !wfull;
    assign rd_acc = rinc && !rempty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_acc) begin
            wptr_d = wptr_q + ONE;
        end
        if (rd_acc) begin
            rptr_d = rptr_q + ONE;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= winc && wfull;
            underflow_q <= rinc && rempty;
        end
    end

    // Storage is deliberately left unreset; the pointers alone decide what is visible.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wptr_q[ASIZE-1:0]] <= wdata;
        end
    end

    if (FWFT == 0) begin : g_std
        logic [DSIZE-1:0] rdata_q;
        logic             rvalid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_acc;
                if (rd_acc) begin
                    rdata_q <= mem_q[rptr_q[ASIZE-1:0]];
                end
            end
        end

        assign rdata  = rdata_q;
        assign rvalid = rvalid_q;
    end else begin : g_fwft
        // Head entry is presented combinationally; forced to zero while empty so reset reads 0.
        assign rdata  = rempty ? '0 : mem_q[rptr_q[ASIZE-1:0]];
        assign rvalid = !rempty;
    end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DSIZE, default 8, data word width in bits.
REQ-002 Parameter ASIZE, default 4, address width; DEPTH = 2**ASIZE entries.
REQ-003 Parameter AF_THRESH, default 14, almost-full threshold in entries; legal range 1..DEPTH.
REQ-004 Parameter AE_THRESH, default 2, almost-empty threshold in entries; legal range 0..DEPTH-1.
REQ-005 Parameter FWFT, default 0; 0 = standard registered-read mode, 1 = first-word-fall-through mode.
REQ-006 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-007 Port rst_n, input, 1, asynchronous active-low reset.
REQ-008 Port winc, input, 1, write request.
REQ-009 Port wdata, input, DSIZE, write data.
REQ-010 Port rinc, input, 1, read request (a pop in FWFT mode).
REQ-011 Port rdata, output, DSIZE, read data.
REQ-012 Port rvalid, output, 1, rdata valid; in FWFT mode equals !rempty.
REQ-013 Port wfull, output, 1, FIFO holds DEPTH entries.
REQ-014 Port rempty, output, 1, FIFO holds 0 entries.
REQ-015 Port walmost_full, output, 1, count >= AF_THRESH.
REQ-016 Port ralmost_empty, output, 1, count <= AE_THRESH.
REQ-017 Port count, output, ASIZE+1, current number of stored entries, 0..DEPTH.
REQ-018 Port overflow, output, 1, one-cycle pulse for a rejected write.
REQ-019 Port underflow, output, 1, one-cycle pulse for a rejected read.

Function
REQ-020 Write accepted iff winc && !wfull; wdata is stored at the write pointer, which then advances by 1.
REQ-021 Read accepted iff rinc && !rempty; the read pointer advances by 1.
REQ-022 Pointers are ASIZE+1 bits and wrap modulo 2*DEPTH; memory index is pointer[ASIZE-1:0]; no entry is lost or duplicated across wrap.
REQ-023 count is registered: +1 on a write-only cycle, -1 on a read-only cycle, unchanged when both or neither are accepted.
REQ-024 wfull, rempty, walmost_full and ralmost_empty derive from registered count and are valid in the cycle after the updating edge.
REQ-025 Simultaneous winc and rinc while full: read accepted, write rejected, overflow pulses, count becomes DEPTH-1.
REQ-026 Simultaneous winc and rinc while empty: write accepted, read rejected, underflow pulses, count becomes 1.
REQ-027 Simultaneous accepted read and write otherwise: both complete and count is unchanged.
REQ-028 Rejected write leaves memory and pointers unchanged; rejected read leaves rdata and pointers unchanged.
REQ-029 overflow and underflow are registered, high for exactly the one cycle after the edge sampling the rejected request, and high on consecutive cycles for consecutive rejected requests.
REQ-030 FWFT=0: on an accepted read, rdata is loaded with the head entry at that edge and rvalid is high for the following cycle only; rdata otherwise holds its last value; read latency is 1 cycle.
REQ-031 FWFT=1: rdata continuously presents the head entry whenever !rempty; a word written to an empty FIFO appears on rdata, with rempty low, in the cycle after its write edge; rdata is don't-care while rempty.
REQ-032 A parameter outside its legal range is a compile-time error.

Reset
REQ-033 While rst_n is low, independent of clk: pointers = 0, count = 0, rempty = 1, ralmost_empty = 1, wfull = 0, walmost_full = 0, overflow = 0, underflow = 0, rvalid = 0, rdata = 0.
REQ-034 Reset asserted mid-operation discards all stored entries; memory contents are not cleared and are never observable afterwards.
REQ-035 After rst_n deasserts, the first rising clk edge processes winc and rinc normally.

Verification (DSIZE=8, ASIZE=4, AF_THRESH=14, AE_THRESH=2)
REQ-036 Fill and drain, FWFT=0: write 0x00..0x0F -> wfull=1 and count=16 after the 16th edge; 16 reads -> rdata 0x00..0x0F in order, each with a 1-cycle rvalid pulse; rempty=1 at the end.
REQ-037 Thresholds: write 3 words -> ralmost_empty drops after the 3rd edge; write to 14 -> walmost_full rises after the 14th edge; read back to 13 -> walmost_full=0.
REQ-038 Overflow and underflow: write while full -> overflow pulse, count stays 16, no data corrupted; read while empty -> underflow pulse, rdata unchanged.
REQ-039 Simultaneous events: winc+rinc when full -> count=15 and overflow=1; when empty -> count=1 and underflow=1; at count=8 -> count stays 8 with data order preserved.
REQ-040 FWFT=1: write 0xA5 into an empty FIFO -> next cycle rempty=0, rvalid=1 and rdata=0xA5 with no rinc; pop -> rempty=1.
REQ-041 Wrap and reset: stream 40 words with continuous rinc -> order preserved across pointer wrap; assert rst_n=0 at count=9 -> all outputs at reset values immediately, including count=0.
